upsampler: RTL and testbench
============================

Name: upsampler

Overview:
- Polyphase interpolating FIR upsampler; the inverse-direction counterpart of the analogue-path decimator.
- Each accepted low-rate sample produces UPSAMPLE_FACTOR output samples. Each output is filtered by one coefficient phase using a sequential multiply-accumulate (MAC).
- Sits between sample processing and the analogue output/DAC path.
- Single clock domain. Valid/ready handshakes on input and output. Coefficients load through a runtime write port.

Parameters:
- IN_DATA_WIDTH, 12, signed input sample width.
- OUT_DATA_WIDTH, 12, signed output sample width.
- COEFF_WIDTH, 8, signed coefficient width, format Q1.(COEFF_WIDTH-1).
- UPSAMPLE_FACTOR, 4, interpolation factor L (≥2).
- TAPS_PER_PHASE, 4, taps per polyphase branch T (≥1).
- Derived: NUM_TAPS = L*T; ACC_WIDTH = IN_DATA_WIDTH+COEFF_WIDTH+clog2(T)+1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- in_valid  in  1  input sample valid.
- in_ready  out  1  upsampler can accept a sample.
- in_data  in  IN_DATA_WIDTH  signed input sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_DATA_WIDTH  signed interpolated sample.
- coeff_we  in  1  coefficient write strobe.
- coeff_addr  in  clog2(NUM_TAPS)  coefficient index.
- coeff_wdata  in  COEFF_WIDTH  signed coefficient value.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; in_ready=1 once released.
  - out_valid=0, out_data=0.
  - Delay line x[0..T-1]=0, all coeffs=0, phase=0, tap=0, acc=0.
- Reset mid-operation aborts immediately. The pending output is lost.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x[0]<=in_data, x[k]<=x[k-1], phase<=0, tap<=0, acc<=0, go MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc += coeff[phase + tap*L] * x[tap] (signed, full precision); tap++.
  - On the cycle with tap==T-1: out_data <= sat(floor((acc+product) >>> (COEFF_WIDTH-1))); go OUT.
- OUT:
  - out_valid=1. out_data and out_valid hold stable until out_ready.
  - On out_valid&&out_ready:
    - if phase==L-1: go IDLE.
    - else: phase++, tap<=0, acc<=0, go MAC.
- Latency: out_valid rises T clock edges after the accepting edge.
- Throughput with out_ready=1: one output per T+1 cycles; one input accepted per L*(T+1)+1 cycles.
- Arithmetic:
  - Arithmetic right shift, i.e. truncation toward -inf.
  - Saturation clamps to [-2^(OUT-1), 2^(OUT-1)-1].
- Coefficient write:
  - coeff_we writes coeff[coeff_addr] at the clock edge, legal in any state.
  - A MAC cycle on the same edge uses the old value.
  - coeff_addr ≥ NUM_TAPS is ignored.
- clear (sync, priority over all except rst_n):
  - Zeroes the delay line, acc, phase and tap; state=IDLE; out_valid=0.
  - Coefficients are retained.
  - A handshake on the same edge is discarded.
- in_ready is never asserted outside IDLE. No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- Reset defaults, coeffs all 0: send in_data=100 -> four outputs, all 0; in_ready low until the 4th out handshake.
- Impulse (L=4, T=4): coeff[i]=i+1 for i=0..15; send 128,0,0,0 -> out_data sequence 1,2,…,16; first out_valid exactly 4 edges after the accept.
- Saturation: all coeffs 127; send 2047 ×4 -> 16th output = 2047 (raw 8124). Then send -2048 ×4 -> the corresponding fully-loaded output = -2048 (raw -8128).
- Backpressure: out_ready=0 for 10 cycles during OUT -> out_valid and out_data stable, in_ready=0. Raise out_ready -> sequence resumes with no loss or duplication.
- Coefficient write during MAC and clear mid-burst:
  - Write coeff[1]=64 on the edge of the phase-1 MAC using coeff[1] -> that output uses the old value.
  - Assert clear in phase 2 -> out_valid=0 next cycle, in_ready=1, next impulse reproduces 1..16.
- Async reset mid-MAC: drop rst_n between edges -> outputs clear immediately without a clock edge; after release, coeffs read 0 (impulse -> all 0 outputs).

Source files
------------

// File: rtl/upsampler.sv
// Polyphase interpolating FIR: each accepted input yields UPSAMPLE_FACTOR outputs,
// each produced by a sequential MAC over one coefficient phase of the delay line.
module upsampler #(
    parameter int IN_DATA_WIDTH   = 12,
    parameter int OUT_DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH     = 8,
    parameter int UPSAMPLE_FACTOR = 4,
    parameter int TAPS_PER_PHASE  = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   clear,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [IN_DATA_WIDTH-1:0]                               in_data,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [OUT_DATA_WIDTH-1:0]                              out_data,
    input  logic                                                   coeff_we,
    input  logic [$clog2(UPSAMPLE_FACTOR*TAPS_PER_PHASE)-1:0]      coeff_addr,
    input  logic [COEFF_WIDTH-1:0]                                 coeff_wdata
);

    localparam int L        = UPSAMPLE_FACTOR;
    localparam int T        = TAPS_PER_PHASE;
    localparam int NUM_TAPS = L * T;
    localparam int AW       = $clog2(NUM_TAPS);
    localparam int TW       = (T > 1) ? $clog2(T) : 1;
    localparam int PW       = $clog2(L);
    localparam int PROD_W   = IN_DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W    = IN_DATA_WIDTH + COEFF_WIDTH + $clog2(T) + 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_DATA_WIDTH+1){1'b0}}, {(OUT_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_DATA_WIDTH+1){1'b1}}, {(OUT_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [COEFF_WIDTH-1:0]   coeff [NUM_TAPS];
    logic signed [IN_DATA_WIDTH-1:0] x     [T];
    logic [PW-1:0]                   phase;
    logic [TW-1:0]                   tap;
    logic [AW-1:0]                   cidx;
    logic signed [ACC_W-1:0]         acc;

    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         sum;
    logic signed [ACC_W-1:0]         scaled;
    logic [OUT_DATA_WIDTH-1:0]       sat_val;
    logic                            last_tap;
    logic                            last_phase;

    assign last_tap   = (tap == TW'(T - 1));
    assign last_phase = (phase == PW'(L - 1));
    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_OUT);

    // cidx walks phase, phase+L, phase+2L ... so no multiplier is needed for the index
    always_comb begin
        prod   = coeff[cidx] * x[tap];
        sum    = acc + ACC_W'(prod);
        scaled = sum >>> (COEFF_WIDTH - 1);
        if (scaled > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_DATA_WIDTH-1:0];
        end else if (scaled < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_DATA_WIDTH-1:0];
        end else begin
            sat_val = scaled[OUT_DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (in_valid) state_next = S_MAC;
            S_MAC:  if (last_tap) state_next = S_OUT;
            S_OUT:  if (out_ready) state_next = last_phase ? S_IDLE : S_MAC;
            default: state_next = S_IDLE;
        endcase
        if (clear) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) coeff[i] <= '0;
            for (int k = 0; k < T; k++) x[k] <= '0;
            phase    <= '0;
            tap      <= '0;
            cidx     <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            // Addresses at or beyond NUM_TAPS never match and are dropped
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coeff_we && coeff_addr == AW'(i)) coeff[i] <= coeff_wdata;
            end
            if (clear) begin
                for (int k = 0; k < T; k++) x[k] <= '0;
                phase <= '0;
                tap   <= '0;
                cidx  <= '0;
                acc   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            x[0] <= in_data;
                            for (int k = 1; k < T; k++) x[k] <= x[k-1];
                            phase <= '0;
                            tap   <= '0;
                            cidx  <= '0;
                            acc   <= '0;
                        end
                    end
                    S_MAC: begin
                        acc  <= sum;
                        tap  <= tap + TW'(1);
                        cidx <= cidx + AW'(L);
                        if (last_tap) out_data <= sat_val;
                    end
                    S_OUT: begin
                        if (out_ready && !last_phase) begin
                            phase <= phase + PW'(1);
                            tap   <= '0;
                            cidx  <= AW'(phase) + AW'(1);
                            acc   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upsampler.sv
// Self-checking bench for upsampler: arithmetic polyphase model plus a per-cycle
// scoreboard, with directed impulse/saturation/backpressure/clear/reset cases.
module tb_upsampler;

    localparam int L = 4;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_data;
    logic        coeff_we = 1'b0;
    logic [3:0]  coeff_addr = '0;
    logic [7:0]  coeff_wdata = '0;

    int checks = 0;
    int errors = 0;

    int mcoef [L*T];
    int mx    [T];
    int exp_q [$];
    int got_q [$];
    int n_out = 0;
    bit rand_bp = 1'b0;
    bit prev_stall = 1'b0;
    int prev_data = 0;

    upsampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endfunction

    // One output of phase p: full-precision dot product, floor shift, clamp
    function automatic int model_out(input int p);
        int s = 0;
        for (int t = 0; t < T; t++) s += mcoef[p + t*L] * mx[t];
        s = s >>> 7;
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int t = 0; t < T; t++) mx[t] = 0;
            for (int i = 0; i < L*T; i++) mcoef[i] = 0;
            prev_stall = 1'b0;
        end else begin
            if (out_valid) check("ready_low_in_out", int'(in_ready), 0);
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'($signed(out_data)), prev_data);
            end
            if (clear) begin
                exp_q.delete();
                for (int t = 0; t < T; t++) mx[t] = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        check("out_data", int'($signed(out_data)), exp_q.pop_front());
                    end
                    got_q.push_back(int'($signed(out_data)));
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    for (int t = T-1; t > 0; t--) mx[t] = mx[t-1];
                    mx[0] = int'($signed(in_data));
                    for (int p = 0; p < L; p++) exp_q.push_back(model_out(p));
                end
            end
            if (coeff_we) mcoef[coeff_addr] = int'($signed(coeff_wdata));
            prev_stall = out_valid && !out_ready && !clear;
            prev_data  = int'($signed(out_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 12'(v);
        while (!in_ready && n < 500) begin tick(); n++; end
        if (n >= 500) fail_now("send");
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wcoef(input int a, input int d);
        coeff_we    = 1'b1;
        coeff_addr  = 4'(a);
        coeff_wdata = 8'(d);
        tick();
        coeff_we = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        if (n >= 200) fail_now("wait_valid");
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin tick(); n++; end
        if (n >= 2000) fail_now("drain");
    endtask

    task automatic check_impulse(input string name);
        check({name, "_count"}, got_q.size(), 16);
        if (got_q.size() == 16)
            for (int i = 0; i < 16; i++) check(name, got_q[i], i + 1);
    endtask

    initial begin
        int n;
        int base;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset defaults
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", int'(in_ready), 1);

        // All-zero coefficients: four zero outputs, 20 busy cycles
        got_q.delete();
        send(100);
        check("busy_after_accept", int'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check("busy_cycles", n, L*(T+1));
        check("zero_count", got_q.size(), 4);
        foreach (got_q[i]) check("zero_out", got_q[i], 0);

        // Impulse through coeff[i] = i+1
        for (int i = 0; i < 16; i++) wcoef(i, i + 1);
        pulse_clear();
        got_q.delete();
        send(128);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("latency", n, T);
        send(0); send(0); send(0);
        drain();
        check_impulse("impulse");

        // Saturation in both directions
        for (int i = 0; i < 16; i++) wcoef(i, 127);
        got_q.delete();
        repeat (4) send(2047);
        drain();
        if (got_q.size() == 16) check("sat_pos", got_q[15], 2047);
        else fail_now("sat_pos_count");
        got_q.delete();
        repeat (4) send(-2048);
        drain();
        if (got_q.size() == 16) check("sat_neg", got_q[15], -2048);
        else fail_now("sat_neg_count");

        // Backpressure: stall 10 cycles in OUT
        n = n_out;
        out_ready = 1'b0;
        send(-700);
        wait_valid();
        repeat (10) begin
            tick();
            check("bp_valid", int'(out_valid), 1);
            check("bp_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        drain();
        check("bp_outputs", n_out - n, 4);

        // Coefficient write on a MAC edge, then clear mid-burst
        for (int i = 0; i < 16; i++) wcoef(i, i + 1);
        pulse_clear();
        got_q.delete();
        send(128);
        wait_valid();
        tick();
        wcoef(1, 64);
        wait_valid();
        check("old_coeff_used", int'($signed(out_data)), 2);
        tick();
        tick();
        pulse_clear();
        check("clear_valid", int'(out_valid), 0);
        check("clear_ready", int'(in_ready), 1);
        check("clear_count", got_q.size(), 2);
        wcoef(1, 2);
        got_q.delete();
        send(128); send(0); send(0); send(0);
        drain();
        check_impulse("impulse_after_clear");

        // Randomized traffic, coefficients, backpressure and clears
        rand_bp = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                wcoef($urandom_range(0, 15), $urandom_range(0, 255));
            end
            send($urandom_range(0, 4095) - 2048);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 12)) tick();
                pulse_clear();
            end
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;

        // Async reset while computing phase 1
        for (int i = 0; i < 16; i++) wcoef(i, i + 1);
        pulse_clear();
        send(128);
        wait_valid();
        tick();
        tick();
        check("pre_reset_data", int'($signed(out_data)), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", int'(out_valid), 0);
        check("areset_data", int'(out_data), 0);
        check("areset_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        got_q.delete();
        send(128);
        drain();
        check("post_reset_count", got_q.size(), 4);
        foreach (got_q[i]) check("post_reset_zero", got_q[i], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
